// File: rtl/digit_serial_tx.sv
// Parallel-in, serial-out BCD digit transmitter: captures DIGITS nibbles and shifts
// them out MSB-first at DIV clocks per bit, with bit/digit strobes and a done pulse.
module digit_serial_tx #(
   parameter int DIGITS = 4,
   parameter int DIV    = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [4*DIGITS-1:0]   DIN,
   output logic                  SOUT,
   output logic                  BIT_STB,
   output logic                  DIGIT_STB,
   output logic                  BUSY,
   output logic                  DONE
);

   localparam int NBITS = 4 * DIGITS;
   localparam int CW    = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [NBITS-1:0]   sh_q, sh_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [DW-1:0]      div_q, div_d;
   logic               bit_end;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
      end
   end

   assign bit_end = (div_q == DW'(DIV - 1));

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      SOUT      = 1'b0;
      BIT_STB   = 1'b0;
      DIGIT_STB = 1'b0;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               sh_d    = DIN;
               cnt_d   = CW'(NBITS - 1);
               div_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            BUSY = 1'b1;
            SOUT = sh_q[NBITS-1];
            if (bit_end) begin
               BIT_STB   = 1'b1;
               // bit counter counts down, so a nibble's last bit has low bits 00
               DIGIT_STB = (cnt_q[1:0] == 2'b00);
               div_d     = '0;
               if (cnt_q == '0) begin
                  state_d = S_FIN;
               end else begin
                  sh_d  = {sh_q[NBITS-2:0], 1'b0};
                  cnt_d = cnt_q - CW'(1);
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         S_FIN: begin
            DONE    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_digit_serial_tx.sv
// Bench for digit_serial_tx: four parameterisations checked every cycle against a
// frame-position model, plus literal expectations for each directed scenario.
module tb_digit_serial_tx;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start [4];
   logic [15:0] din   [4];
   logic        sout  [4];
   logic        bstb  [4];
   logic        dstb  [4];
   logic        busy  [4];
   logic        done  [4];

   int errors = 0;
   int checks = 0;
   int gc     = 0;

   // model: cycles since frame accept (0 = idle) and captured data per instance
   int          mj   [4];
   logic [15:0] mcap [4];

   logic [127:0] ms, mb, md, mbu, mdn;

   function automatic int dg(int i);
      return (i == 3) ? 1 : 4;
   endfunction

   function automatic int dv(int i);
      case (i)
         0: return 1;
         1: return 4;
         2: return 2;
         default: return 3;
      endcase
   endfunction

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DGC = dg(g);
      localparam int DVC = dv(g);
      digit_serial_tx #(.DIGITS(DGC), .DIV(DVC)) u_dut (
         .CLK       (CLK),
         .RST       (RST),
         .START     (start[g]),
         .DIN       (din[g][4*DGC-1:0]),
         .SOUT      (sout[g]),
         .BIT_STB   (bstb[g]),
         .DIGIT_STB (dstb[g]),
         .BUSY      (busy[g]),
         .DONE      (done[g])
      );
   end

   task automatic chk(string name, int inst, logic got, logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cycle%0d got=%b exp=%b", name, inst, gc, got, exp);
      end
   endtask

   task automatic chkv(string name, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] word16(logic [127:0] m, int first, int stride);
      logic [15:0] w = '0;
      for (int j = 0; j < 16; j++) w = {w[14:0], m[first + j*stride]};
      return w;
   endfunction

   task automatic step(int i, int c);
      int n, d, k;
      logic es, eb, ed, ebu, edn;
      @(negedge CLK);
      for (int x = 0; x < 4; x++) begin
         n = 4 * dg(x);
         d = dv(x);
         es = 0; eb = 0; ed = 0; ebu = 0; edn = 0;
         if (mj[x] >= 1 && mj[x] <= n*d) begin
            k   = n - 1 - (mj[x] - 1) / d;
            es  = mcap[x][k];
            eb  = (mj[x] % d == 0);
            ed  = eb && (k % 4 == 0);
            ebu = 1;
         end else if (mj[x] == n*d + 1) begin
            edn = 1;
         end
         chk("SOUT", x, sout[x], es);
         chk("BIT_STB", x, bstb[x], eb);
         chk("DIGIT_STB", x, dstb[x], ed);
         chk("BUSY", x, busy[x], ebu);
         chk("DONE", x, done[x], edn);
      end
      ms[c] = sout[i]; mb[c] = bstb[i]; md[c] = dstb[i]; mbu[c] = busy[i]; mdn[c] = done[i];
      for (int x = 0; x < 4; x++) begin
         n = 4 * dg(x);
         d = dv(x);
         if (RST) mj[x] = 0;
         else if (mj[x] == 0) begin
            if (start[x]) begin
               mj[x]   = 1;
               mcap[x] = din[x];
            end
         end else if (mj[x] == n*d + 1) mj[x] = 0;
         else mj[x] = mj[x] + 1;
      end
      gc++;
      @(posedge CLK);
      #1;
   endtask

   task automatic run(int i, int ncyc, logic [127:0] stm, logic [127:0] rstm,
                      int chg, logic [15:0] val);
      ms = '0; mb = '0; md = '0; mbu = '0; mdn = '0;
      for (int c = 0; c <= ncyc; c++) begin
         start[i] = stm[c];
         RST      = rstm[c];
         if (c == chg) din[i] = val;
         step(i, c);
      end
      start[i] = 1'b0;
      RST      = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      for (int x = 0; x < 4; x++) begin
         start[x] = 1'b0;
         din[x]   = '0;
         mj[x]    = 0;
         mcap[x]  = '0;
      end
      @(posedge CLK);
      #1;

      // reset state
      run(0, 3, '0, 128'h7, -1, '0);
      chkv("RST_outputs", ms[3:0] | mb[3:0] | md[3:0] | mbu[3:0] | mdn[3:0], '0);

      // T1: DIV=1, 0x1234
      din[0] = 16'h1234;
      run(0, 20, 128'h1, '0, -1, '0);
      chkv("T1_word", word16(ms, 1, 1), 16'h1234);
      chkv("T1_bitstb", mb[20:0], 21'h1FFFE);
      chkv("T1_digstb", md[20:0], 21'h11110);
      chkv("T1_done", mdn[20:0], 21'h20000);
      chkv("T1_busy", mbu[20:0], 21'h1FFFE);

      // T2: DIV=4, 0x9A05
      din[1] = 16'h9A05;
      run(1, 70, 128'h1, '0, -1, '0);
      chkv("T2_first_bit", ms[4:1], 4'hF);
      chkv("T2_second_bit", ms[8:5], 4'h0);
      chkv("T2_word", word16(ms, 4, 4), 16'h9A05);
      chkv("T2_bitstb_count", $countones(mb), 16);
      chkv("T2_bitstb_last", {mb[64], mb[63], mb[4]}, 3'b101);
      chkv("T2_digstb", md, (128'd1 << 16) | (128'd1 << 32) | (128'd1 << 48) | (128'd1 << 64));
      chkv("T2_done", mdn, 128'd1 << 65);

      // T3: restarts ignored, DIN change after capture ignored, accept from 18
      din[0] = 16'h1234;
      run(0, 37, (128'd1 << 0) | (128'd1 << 5) | (128'd1 << 17) | (128'd1 << 18),
          '0, 3, 16'hFFFF);
      chkv("T3_word", word16(ms, 1, 1), 16'h1234);
      chkv("T3_no_restart", {mbu[19], mbu[18], mbu[17]}, 3'b100);
      chkv("T3_second_frame", word16(ms, 19, 1), 16'hFFFF);
      chkv("T3_done", mdn, (128'd1 << 17) | (128'd1 << 35));

      // T4: reset mid-frame, clean restart
      din[0] = 16'h1234;
      run(0, 30, (128'd1 << 0) | (128'd1 << 11), 128'd1 << 9, -1, '0);
      chkv("T4_busy_before", {mbu[9], mbu[10], mbu[11], mbu[12]}, 4'b1001);
      chkv("T4_cycle10_zero", {ms[10], mb[10], md[10], mbu[10], mdn[10]}, 5'b0);
      chkv("T4_word", word16(ms, 12, 1), 16'h1234);
      chkv("T4_done", mdn, 128'd1 << 28);

      // T5: START held, DIV=2, 0x8001
      din[2] = 16'h8001;
      run(2, 70, '1, '0, -1, '0);
      chkv("T5_done", mdn, (128'd1 << 33) | (128'd1 << 67));
      chkv("T5_frame1_sout", ms[34:1], {2'b00, 2'b11, 28'h0, 2'b11});
      chkv("T5_frame2_edges", {ms[66:65], ms[36:35], mbu[34]}, 5'b11110);

      // T6: DIGITS=1, DIV=3, 0xB
      din[3] = 16'h000B;
      run(3, 15, 128'h1, '0, -1, '0);
      chkv("T6_sout", ms[12:1], 12'hFC7);
      chkv("T6_bitstb", mb[15:0], 16'h1248);
      chkv("T6_digstb", md[15:0], 16'h1000);
      chkv("T6_done", mdn[15:0], 16'h2000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/digit_serial_tx.md
Name: digit_serial_tx

Overview:
Parallel-in, serial-out transmitter for the calculator's digit datapath. It is the counterpart of the serial-in nibble shift register used for digit entry.
- Captures DIGITS BCD nibbles in one cycle.
- Shifts them out MSB-first on a single line at a programmable bit rate.
- Emits per-bit and per-digit strobes plus a frame-complete pulse, so a downstream serial-in register or display link can rebuild the digits.

Parameters:
DIGITS, 4, number of 4-bit nibbles per frame (>=1); frame length NBITS = 4*DIGITS
DIV, 4, CLK cycles per serial bit (>=1)

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request a frame; sampled only in IDLE
DIN  input  4*DIGITS  parallel data; DIN[4*DIGITS-1] is transmitted first
SOUT  output  1  serial data, held stable for DIV cycles per bit
BIT_STB  output  1  1-cycle pulse on the last cycle of each bit period (sample point)
DIGIT_STB  output  1  1-cycle pulse coincident with BIT_STB of bit 0 of each nibble
BUSY  output  1  high while a frame is shifting
DONE  output  1  1-cycle pulse after the last bit period

Behaviour:
- Clocking and reset:
  - Reset is RST, synchronous, active-high; clock is CLK.
  - RST has priority over everything, including mid-frame.
  - Next edge: state=IDLE; shift register, bit counter and divider cleared; SOUT=BUSY=DONE=BIT_STB=DIGIT_STB=0.
- State machine: IDLE, SHIFT, FIN.
- IDLE:
  - All outputs 0.
  - START=1 at an edge: load DIN into the NBITS shift register, bit counter=NBITS-1, divider=0, go to SHIFT.
- SHIFT:
  - BUSY=1; SOUT = shift register MSB (registered output, no combinational path from DIN).
  - Divider counts 0..DIV-1.
  - When divider==DIV-1: BIT_STB=1 for that cycle; DIGIT_STB=1 if bit counter[1:0]==0.
  - On the following edge: divider=0, shift register shifts left with 0 fill, bit counter decrements.
  - If bit counter==0 at the strobe, go to FIN instead.
- FIN:
  - DONE=1 and BUSY=0 for exactly one cycle, then IDLE unconditionally.
  - START is ignored in FIN.
- Latency:
  - START sampled at edge 0: first bit valid in cycles 1..DIV.
  - Bit k (k=NBITS-1 down to 0) is valid in cycles (NBITS-1-k)*DIV+1 .. (NBITS-k)*DIV.
  - DONE is in cycle NBITS*DIV+1.
  - Earliest next START is accepted at edge NBITS*DIV+2, so the frame period with START held high is NBITS*DIV+2 cycles.
- START handling:
  - START while BUSY or in FIN has no effect. It is not queued.
  - DIN changes after capture do not affect the frame in progress.
- Strobe counts: exactly NBITS BIT_STB and DIGITS DIGIT_STB pulses per frame.
- DIV=1: SOUT changes every cycle and BIT_STB is high for all NBITS SHIFT cycles.
- Counters:
  - Bit counter width = clog2(NBITS), minimum 1.
  - Divider width = clog2(DIV), minimum 1.
  - No wrap-around is reachable in legal operation.

Test Plan:
1. DIGITS=4, DIV=1, DIN=16'h1234, START pulse at cycle 0 -> cycles 1-16 SOUT = 0001 0010 0011 0100; BIT_STB high cycles 1-16; DIGIT_STB at cycles 4, 8, 12, 16; DONE only at cycle 17; BUSY high cycles 1-16.
2. DIV=4, DIN=16'h9A05 -> each bit held 4 cycles; 16 BIT_STB pulses at cycles 4, 8, …, 64; 4 DIGIT_STB at 16, 32, 48, 64; DONE at cycle 65; SOUT is 1 in cycles 1-4 (bit 15 of 9A05 = 1).
3. DIV=1: START re-pulsed at cycles 5 and 17, DIN changed to 16'hFFFF at cycle 3 -> frame still 0x1234; no restart; DONE once at 17; the next START is accepted only from cycle 18.
4. RST asserted at cycle 9 of a DIV=1 frame -> at cycle 10 all outputs 0, state IDLE; a START at cycle 11 starts a clean frame with first bit at cycle 12.
5. START held high continuously, DIV=2, DIN=16'h8001 -> frames start every 34 cycles; SOUT is 1 for the first 2 and last 2 bit cycles of each frame, otherwise 0; DONE pulses at cycles 33 and 67.
6. DIGITS=1, DIV=3, DIN=4'hB -> SOUT = 1,0,1,1 for 3 cycles each (cycles 1-12); a single DIGIT_STB at cycle 12; DONE at cycle 13.
